// File: rtl/soc_now_wb_arbiter.sv
// rtl/soc_now_wb_arbiter.sv - two-master round-robin Wishbone arbiter with bus-cycle lock and ack watchdog
// Shares one slave port between the management bus (m0) and the LA debug master (m1).
module soc_now_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
    output logic        timeout_irq_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        req0, req1;
    logic        own0, own1, own_any;
    logic        act_cyc, act_stb, act_we;
    logic [3:0]  act_sel;
    logic [31:0] act_adr, act_dat;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign own0    = (state_q == OWN0);
    assign own1    = (state_q == OWN1);
    assign own_any = own0 | own1;

    assign act_cyc = own1 ? m1_cyc_i : m0_cyc_i;
    assign act_stb = own1 ? m1_stb_i : m0_stb_i;
    assign act_we  = own1 ? m1_we_i  : m0_we_i;
    assign act_sel = own1 ? m1_sel_i : m0_sel_i;
    assign act_adr = own1 ? m1_adr_i : m0_adr_i;
    assign act_dat = own1 ? m1_dat_i : m0_dat_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // last_q only moves on entry to an OWN state, so after an abort it still names the aborted master.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                end else if (req0) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!act_cyc) begin
                    state_d = IDLE;
                end else if (act_stb && !s_ack_i) begin
                    cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ABORT;
                    end
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_cyc_o = own_any ? act_cyc : 1'b0;
    assign s_stb_o = own_any ? act_stb : 1'b0;
    assign s_we_o  = own_any ? act_we  : 1'b0;
    assign s_sel_o = own_any ? act_sel : 4'h0;
    assign s_adr_o = own_any ? act_adr : 32'h0;
    assign s_dat_o = own_any ? act_dat : 32'h0;

    assign m0_ack_o = own0 & s_ack_i;
    assign m1_ack_o = own1 & s_ack_i;
    assign m0_dat_o = own0 ? s_dat_i : 32'h0;
    assign m1_dat_o = own1 ? s_dat_i : 32'h0;
    assign m0_err_o = (state_q == ABORT) & ~last_q;
    assign m1_err_o = (state_q == ABORT) &  last_q;

    assign grant_o       = {own1, own0};
    assign timeout_irq_o = (state_q == ABORT);

endmodule

// File: tb/tb_soc_now_wb_arbiter.sv
// tb/tb_soc_now_wb_arbiter.sv - directed and randomized bench for soc_now_wb_arbiter
// Expected outputs come from an owner/stall-count model of the arbitration rules.
module tb_soc_now_wb_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic [31:0] s_rdat;
    logic        s_ack;
    logic [1:0]  grant;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner 0 = idle, 1 = m0, 2 = m1, 3 = abort cycle; last = index of last granted master.
    int m_owner, m_last, m_stall;

    soc_now_wb_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .grant_o(grant), .timeout_irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_dat = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_dat = 0;
        s_ack = 0; s_rdat = 0;
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 1; m_stall = 0;
    endtask

    task automatic model_step();
        logic r0, r1, cx, sx;
        if (rst_n) begin
            r0 = m0_cyc & m0_stb;
            r1 = m1_cyc & m1_stb;
            if (m_owner == 0) begin
                if (r0 && r1) begin
                    m_owner = (m_last == 0) ? 2 : 1;
                    m_last  = m_owner - 1;
                end else if (r0) begin
                    m_owner = 1; m_last = 0;
                end else if (r1) begin
                    m_owner = 2; m_last = 1;
                end
            end else if (m_owner == 3) begin
                m_owner = 0;
            end else begin
                cx = (m_owner == 1) ? m0_cyc : m1_cyc;
                sx = (m_owner == 1) ? m0_stb : m1_stb;
                if (!cx) begin
                    m_owner = 0; m_stall = 0;
                end else if (sx && !s_ack) begin
                    m_stall++;
                    if (m_stall >= T) begin
                        m_owner = 3; m_stall = 0;
                    end
                end else begin
                    m_stall = 0;
                end
            end
        end
    endtask

    task automatic model_check();
        logic e_cyc, e_stb, e_we, e_a0, e_a1, e_e0, e_e1, e_irq;
        logic [1:0]  e_g;
        logic [3:0]  e_sel;
        logic [31:0] e_adr, e_dat, e_d0, e_d1;
        e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_adr = 0; e_dat = 0;
        e_a0 = 0; e_a1 = 0; e_e0 = 0; e_e1 = 0; e_irq = 0; e_g = 0; e_d0 = 0; e_d1 = 0;
        if (m_owner == 1) begin
            e_cyc = m0_cyc; e_stb = m0_stb; e_we = m0_we; e_sel = m0_sel; e_adr = m0_adr; e_dat = m0_dat;
            e_a0 = s_ack; e_d0 = s_rdat; e_g = 2'b01;
        end else if (m_owner == 2) begin
            e_cyc = m1_cyc; e_stb = m1_stb; e_we = m1_we; e_sel = m1_sel; e_adr = m1_adr; e_dat = m1_dat;
            e_a1 = s_ack; e_d1 = s_rdat; e_g = 2'b10;
        end else if (m_owner == 3) begin
            e_irq = 1;
            if (m_last == 0) e_e0 = 1; else e_e1 = 1;
        end
        chk("model_s_cyc", 32'(s_cyc), 32'(e_cyc));
        chk("model_s_stb", 32'(s_stb), 32'(e_stb));
        chk("model_s_we", 32'(s_we), 32'(e_we));
        chk("model_s_sel", 32'(s_sel), 32'(e_sel));
        chk("model_s_adr", s_adr, e_adr);
        chk("model_s_dat", s_wdat, e_dat);
        chk("model_m0_ack", 32'(m0_ack), 32'(e_a0));
        chk("model_m1_ack", 32'(m1_ack), 32'(e_a1));
        chk("model_m0_err", 32'(m0_err), 32'(e_e0));
        chk("model_m1_err", 32'(m1_err), 32'(e_e1));
        chk("model_m0_dat", m0_rdat, e_d0);
        chk("model_m1_dat", m1_rdat, e_d1);
        chk("model_grant", 32'(grant), 32'(e_g));
        chk("model_irq", 32'(irq), 32'(e_irq));
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        model_check();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        cyc_begin();
        cyc_end();
    endtask

    task automatic apply_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic rand_master(inout logic cyc, inout logic stb, output logic we,
                               output logic [3:0] sel, output logic [31:0] adr, output logic [31:0] dat);
        if (cyc) begin
            if ($urandom_range(0, 7) == 0) cyc = 0;
        end else if ($urandom_range(0, 3) == 0) begin
            cyc = 1;
        end
        stb = ($urandom_range(0, 7) != 0);
        we  = 1'($urandom_range(0, 1));
        sel = 4'($urandom);
        adr = $urandom;
        dat = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] seq[$];
        logic [1:0] g, prev_g;
        logic a0, a1, no_ack;
        int idle_run;

        // Reset values
        rst_n = 0;
        clear_inputs();
        model_reset();
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_s_cyc", 32'(s_cyc), 0);
        chk("rst_s_stb", 32'(s_stb), 0);
        chk("rst_s_adr", s_adr, 0);
        chk("rst_m0_ack", 32'(m0_ack), 0);
        chk("rst_m1_err", 32'(m1_err), 0);

        // Single m0 write, acked in the first owned cycle
        apply_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h3000_0000; m0_dat = 32'hDEAD_BEEF;
        cyc_begin(); chk("t1_c0_grant", 32'(grant), 0); cyc_end();
        s_ack = 1; s_rdat = 32'h1234_5678;
        cyc_begin();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_s_cyc", 32'(s_cyc), 1);
        chk("t1_s_we", 32'(s_we), 1);
        chk("t1_s_sel", 32'(s_sel), 32'hF);
        chk("t1_s_adr", s_adr, 32'h3000_0000);
        chk("t1_s_dat", s_wdat, 32'hDEAD_BEEF);
        chk("t1_m0_ack", 32'(m0_ack), 1);
        chk("t1_m0_dat", m0_rdat, 32'h1234_5678);
        chk("t1_m1_ack", 32'(m1_ack), 0);
        chk("t1_m1_dat", m1_rdat, 0);
        cyc_end();
        clear_inputs();
        tick(); tick();

        // Tie: alternating tenures with one idle cycle between
        apply_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
        prev_g = 0; idle_run = 0;
        for (int c = 0; c < 60 && seq.size() < 8; c++) begin
            cyc_begin();
            g = grant; a0 = m0_ack; a1 = m1_ack;
            if (g == 0) begin
                idle_run++;
            end else begin
                if (g != prev_g) begin
                    seq.push_back(g);
                    if (seq.size() > 1) chk("t2_idle_gap", 32'(idle_run), 1);
                end
                idle_run = 0;
            end
            prev_g = g;
            cyc_end();
            if (a0 && m0_cyc) begin m0_cyc = 0; m0_stb = 0; end
            else if (!m0_cyc) begin m0_cyc = 1; m0_stb = 1; end
            if (a1 && m1_cyc) begin m1_cyc = 0; m1_stb = 0; end
            else if (!m1_cyc) begin m1_cyc = 1; m1_stb = 1; end
        end
        chk("t2_tenures", 32'(seq.size()), 8);
        for (int i = 0; i < seq.size(); i++) chk("t2_order", 32'(seq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        clear_inputs();
        tick(); tick();

        // m1 locked 4-beat read while m0 waits
        apply_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000_0010;
        tick();
        m0_cyc = 1; m0_stb = 1;
        for (int b = 1; b <= 4; b++) begin
            s_ack = 1; s_rdat = 32'(b);
            cyc_begin();
            chk("t3_grant", 32'(grant), 32'h2);
            chk("t3_m1_dat", m1_rdat, 32'(b));
            chk("t3_m0_ack", 32'(m0_ack), 0);
            cyc_end();
        end
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        cyc_begin(); chk("t3_drop_grant", 32'(grant), 32'h2); cyc_end();
        cyc_begin(); chk("t3_dead_grant", 32'(grant), 0); cyc_end();
        cyc_begin(); chk("t3_m0_grant", 32'(grant), 32'h1); cyc_end();
        clear_inputs();
        tick(); tick();

        // Watchdog abort with no ack
        apply_reset();
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int k = 1; k <= T; k++) begin
            cyc_begin(); chk("t4_stb", 32'(s_stb), 1); cyc_end();
        end
        cyc_begin();
        chk("t4_abort_cyc", 32'(s_cyc), 0);
        chk("t4_abort_err", 32'(m0_err), 1);
        chk("t4_abort_irq", 32'(irq), 1);
        chk("t4_abort_grant", 32'(grant), 0);
        cyc_end();
        m0_cyc = 0; m0_stb = 0;
        cyc_begin(); chk("t4_irq_pulse", 32'(irq), 0); chk("t4_err_pulse", 32'(m0_err), 0); cyc_end();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        cyc_begin(); chk("t4_tie_m1", 32'(grant), 32'h2); cyc_end();
        clear_inputs();
        tick(); tick();

        // Ack in the last strobe cycle before the limit
        apply_reset();
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int k = 1; k < T; k++) tick();
        s_ack = 1;
        cyc_begin(); chk("t5_ack", 32'(m0_ack), 1); chk("t5_err", 32'(m0_err), 0); cyc_end();
        s_ack = 0;
        cyc_begin(); chk("t5_grant", 32'(grant), 32'h1); chk("t5_irq", 32'(irq), 0); chk("t5_err2", 32'(m0_err), 0); cyc_end();
        clear_inputs();
        tick(); tick();

        // Async reset while m1 owns the bus
        apply_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'hA5A5_0000; s_ack = 0;
        tick();
        tick();
        cyc_begin();
        s_ack = 1;
        rst_n = 0;
        model_reset();
        #1;
        chk("t6_grant", 32'(grant), 0);
        chk("t6_s_cyc", 32'(s_cyc), 0);
        chk("t6_s_stb", 32'(s_stb), 0);
        chk("t6_s_adr", s_adr, 0);
        chk("t6_m1_ack", 32'(m1_ack), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        m0_cyc = 1; m0_stb = 1; s_ack = 0;
        cyc_begin(); chk("t6_idle", 32'(grant), 0); cyc_end();
        cyc_begin(); chk("t6_tie_m0", 32'(grant), 32'h1); cyc_end();
        clear_inputs();
        tick(); tick();

        // Randomized traffic against the model
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            no_ack = (((c / 100) % 4) == 3);
            rand_master(m0_cyc, m0_stb, m0_we, m0_sel, m0_adr, m0_dat);
            rand_master(m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_dat);
            s_ack  = no_ack ? 1'b0 : ($urandom_range(0, 2) == 0);
            s_rdat = $urandom;
            if ($urandom_range(0, 999) == 0) apply_reset();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_now_wb_arbiter.md
# soc_now_wb_arbiter

Two-master, one-slave Wishbone arbiter in front of the SoC-NOW core's Wishbone slave port inside the user project area. Master 0 is the Caravel management Wishbone bus; master 1 is the logic-analyzer debug master. The block shares the single slave port between them using round-robin grant with bus-cycle locking. A watchdog aborts transfers the slave never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: unacknowledged-strobe cycles before abort; legal range 1..65535.

Ports:
- wb_clk_i  in  1  single clock; all logic is on the rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (management) control.
- m0_sel_i  in  4  master 0 byte select.
- m0_adr_i, m0_dat_i  in  32 each  master 0 address and write data.
- m0_dat_o  out  32  master 0 read data.
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge and error.
- m1_*  same set as m0_*  master 1 (LA debug).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side control.
- s_sel_o  out  4  slave-side byte select.
- s_adr_o, s_dat_o  out  32 each  slave-side address and write data.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.
- grant_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle.
- timeout_irq_o  out  1  one-cycle pulse on watchdog abort; drives user_irq[0].

## Operation
- A master requests when its cyc_i and stb_i are both high.
- State machine states: IDLE, OWN0, OWN1, ABORT.
- IDLE:
  - Only one master requests: go to that master's OWNx.
  - Both request: grant the master that was not last granted.
  - Neither requests: stay in IDLE.
- The last-granted register resets to 1, so m0 wins the first tie after reset.
- OWNx:
  - Master x's cyc, stb, we, sel, adr and dat are routed combinationally to s_*.
  - s_dat_i is routed to mx_dat_o, and s_ack_i to mx_ack_o.
  - The last-granted register is updated to x on entry.
- Locking: ownership is held while mx_cyc_i stays high, including across multiple strobes (block transfers). When mx_cyc_i falls, go to IDLE.
- Non-owner master outputs: ack_o = 0, err_o = 0, dat_o = 0.
- s_ack_i arriving while in IDLE or ABORT is ignored.
- Watchdog:
  - The counter increments each cycle in OWNx while s_stb_o = 1 and s_ack_i = 0.
  - It clears on s_ack_i, on any stb low cycle, and on leaving OWNx.
  - Counter width is clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
  - When the counter equals TIMEOUT_CYCLES, go to ABORT.
- ABORT lasts exactly one cycle:
  - s_cyc_o = 0 and s_stb_o = 0.
  - mx_err_o = 1 to the aborted master.
  - timeout_irq_o = 1.
  - Then go to IDLE. The last-granted register stays at x, so the other master gets priority.
- Reset mid-transfer: all state clears immediately and asynchronously. Slave outputs drop the same instant.

## Timing
- Reset values:
  - s_cyc_o, s_stb_o, s_we_o = 0; s_sel_o = 0; s_adr_o, s_dat_o = 0.
  - m*_ack_o, m*_err_o, m*_dat_o = 0.
  - grant_o = 00; timeout_irq_o = 0; state = IDLE.
- Arbitration latency: a request first seen high in IDLE at edge N gives state OWNx after edge N. s_stb_o is high in cycle N+1.
- Acknowledge path is combinational: an ack in cycle N+1 completes the transfer in N+1. A single transfer therefore takes at least 2 cycles.
- Handover: mx_cyc_i low at edge M gives IDLE in cycle M+1. The other master can own the bus from cycle M+2, so there is one dead cycle between tenures.
- Abort: with stb held from cycle K and no ack, the counter reaches TIMEOUT_CYCLES at the edge ending cycle K+TIMEOUT_CYCLES-1. ABORT occupies cycle K+TIMEOUT_CYCLES.
- Ack in the same cycle the counter would hit the limit: the ack wins, the counter clears, and there is no abort.
- Any output derived from state is registered. Pass-through data and acknowledge paths are combinational through a 2:1 mux.

## Test plan
- Reset then m0 single write (adr 0x3000_0000, dat 0xDEADBEEF, sel 0xF), slave acks in the 1st owned cycle -> grant_o = 01 in cycle 1, s_* mirror m0, m0_ack_o high in cycle 1, m1 outputs all 0.
- m0 and m1 request in the same cycle, 4 tenures each -> grants alternate m0, m1, m0, m1, …, with one IDLE cycle between each.
- m1 holds cyc through a 4-beat read (slave data 1, 2, 3, 4) while m0 requests throughout -> m0 is blocked until m1 drops cyc. m1_dat_o shows 1..4. m0 is granted 2 cycles after m1's cyc falls.
- TIMEOUT_CYCLES = 8, slave never acks m0 -> s_stb_o high for 8 cycles. Cycle 9: s_cyc_o = 0, m0_err_o = 1, timeout_irq_o = 1 for one cycle. Next tie is won by m1.
- TIMEOUT_CYCLES = 8, ack in the 8th strobe cycle -> normal completion, no error, no IRQ.
- wb_rst_ni pulsed low mid-transfer during OWN1 -> all outputs go to 0 asynchronously. After release, a tie grants m0.
